bus_host_master: RTL

- Command-driven bus master that drives the system's m0 master port: m0_req, m0_wr, m0_address and m0_dout, and it samples m0_grant and m_din.
- Sits directly upstream of the bus/DMAC/ALU subsystem and replaces hand-driven m0 stimulus.
- Buffers write, read and wait-for-interrupt commands in a small FIFO and executes them one at a time.
- Returns read data on a valid strobe and blocks on a_interrupt / d_interrupt when a wait command asks it to.

---
 rtl/bus_host_master.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_host_master.sv
// ---------------------------------------------------------------------------
// bus_host_master
//
// Command-driven master for the m0 port of the bus/DMAC/ALU subsystem.
// Commands (write, read, wait-for-interrupt, nop) are queued in a small FIFO
// and executed one at a time by a four-state FSM. Read data comes back on a
// one-cycle rd_valid strobe. A wait command blocks until one of its unmasked
// interrupt lines is high.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   cmd_valid    command offered
//   cmd_ready    FIFO can accept a command (not full)
//   cmd_op       00=write, 01=read, 10=wait_irq, 11=nop
//   cmd_addr     bus address for write/read
//   cmd_data     write data; for wait_irq bit0=ALU mask, bit1=DMAC mask
//   m0_req       bus request (registered)
//   m0_wr        1=write, 0=read (registered)
//   m0_address   bus address (registered)
//   m0_dout      bus write data (registered)
//   m0_grant     bus grant
//   m_din        bus read data
//   a_interrupt  ALU interrupt (level)
//   d_interrupt  DMAC interrupt (level)
//   rd_valid     one-cycle strobe, rd_data valid
//   rd_data      captured read data
//   irq_src      sources that satisfied the last wait_irq (bit0 ALU, bit1 DMAC)
//   busy         FIFO non-empty or FSM not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bus_host_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              m0_req,
    output logic              m0_wr,
    output logic [ADDR_W-1:0] m0_address,
    output logic [DATA_W-1:0] m0_dout,
    input  logic              m0_grant,
    input  logic [DATA_W-1:0] m_din,
    input  logic              a_interrupt,
    input  logic              d_interrupt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        irq_src,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Command opcodes; 2'b11 (nop) is handled by the default branch.
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;

    // FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQ      = 2'd1;
    localparam logic [1:0] ST_RD_DATA  = 2'd2;
    localparam logic [1:0] ST_WAIT_IRQ = 2'd3;

    // ------------------------------------------------------------------
    // Command FIFO storage
    // ------------------------------------------------------------------
    logic [1:0]        op_mem   [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // ------------------------------------------------------------------
    // FSM and output registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic [1:0]        cur_op_q,     cur_op_d;
    logic [1:0]        irq_mask_q,   irq_mask_d;
    logic              m0_req_q,     m0_req_d;
    logic              m0_wr_q,      m0_wr_d;
    logic [ADDR_W-1:0] m0_address_q, m0_address_d;
    logic [DATA_W-1:0] m0_dout_q,    m0_dout_d;
    logic              rd_valid_q,   rd_valid_d;
    logic [DATA_W-1:0] rd_data_q,    rd_data_d;
    logic [1:0]        irq_src_q,    irq_src_d;

    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        irq_hit;

    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = (count_q != FULL_CNT);
    assign push       = cmd_valid & cmd_ready;
    // Only an idle FSM consumes a command. Because the head is read from the
    // registered count, a command pushed this edge is not visible until the
    // next one (no bypass path).
    assign pop        = (state_q == ST_IDLE) & ~fifo_empty;

    assign head_op    = op_mem[rd_ptr_q];
    assign head_addr  = addr_mem[rd_ptr_q];
    assign head_data  = data_mem[rd_ptr_q];

    // Interrupt lines are level-sampled against the latched mask.
    assign irq_hit    = {d_interrupt & irq_mask_q[1], a_interrupt & irq_mask_q[0]};

    // ------------------------------------------------------------------
    // FIFO write port (storage is not reset; validity comes from count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]   <= cmd_op;
            addr_mem[wr_ptr_q] <= cmd_addr;
            data_mem[wr_ptr_q] <= cmd_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointer / count next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Command FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cur_op_d     = cur_op_q;
        irq_mask_d   = irq_mask_q;
        m0_req_d     = m0_req_q;
        m0_wr_d      = m0_wr_q;
        m0_address_d = m0_address_q;
        m0_dout_d    = m0_dout_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        irq_src_d    = irq_src_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    cur_op_d = head_op;
                    case (head_op)
                        OP_WRITE: begin
                            state_d      = ST_REQ;
                            m0_req_d     = 1'b1;
                            m0_wr_d      = 1'b1;
                            m0_address_d = head_addr;
                            m0_dout_d    = head_data;
                        end
                        OP_READ: begin
                            state_d      = ST_REQ;
                            m0_req_d     = 1'b1;
                            m0_wr_d      = 1'b0;
                            m0_address_d = head_addr;
                        end
                        OP_WAIT: begin
                            state_d    = ST_WAIT_IRQ;
                            irq_mask_d = head_data[1:0];
                        end
                        default: begin
                            // nop: consumed with no bus activity
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_REQ: begin
                // Request, direction, address and data stay frozen until grant.
                if (m0_grant) begin
                    if (cur_op_q == OP_READ) begin
                        // Keep the request up one more cycle while data returns.
                        state_d = ST_RD_DATA;
                    end else begin
                        state_d  = ST_IDLE;
                        m0_req_d = 1'b0;
                        m0_wr_d  = 1'b0;
                    end
                end
            end

            ST_RD_DATA: begin
                rd_data_d  = m_din;
                rd_valid_d = 1'b1;
                m0_req_d   = 1'b0;
                state_d    = ST_IDLE;
            end

            ST_WAIT_IRQ: begin
                // An all-zero mask can never hit, so it completes immediately
                // rather than blocking forever.
                if ((irq_hit != 2'b00) || (irq_mask_q == 2'b00)) begin
                    irq_src_d = irq_hit;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                m0_req_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            cur_op_q     <= 2'b00;
            irq_mask_q   <= 2'b00;
            m0_req_q     <= 1'b0;
            m0_wr_q      <= 1'b0;
            m0_address_q <= '0;
            m0_dout_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            irq_src_q    <= 2'b00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cur_op_q     <= cur_op_d;
            irq_mask_q   <= irq_mask_d;
            m0_req_q     <= m0_req_d;
            m0_wr_q      <= m0_wr_d;
            m0_address_q <= m0_address_d;
            m0_dout_q    <= m0_dout_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            irq_src_q    <= irq_src_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m0_req     = m0_req_q;
    assign m0_wr      = m0_wr_q;
    assign m0_address = m0_address_q;
    assign m0_dout    = m0_dout_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign irq_src    = irq_src_q;
    assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

endmodule
